// File: rtl/mcb_port_bram.sv
// rtl/mcb_port_bram.sv - Spartan-6 MCB user-port responder backed by on-chip RAM
module mcb_port_bram #(
  parameter int AW        = 12,
  parameter int CALIB_CYC = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);

  localparam int CW    = $clog2(CALIB_CYC + 1);
  localparam int CMD_W = 3 + 6 + AW;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  // ---------------------------------------------------------------------------
  // Calibration timer: calib_done rises after CALIB_CYC edges out of reset
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_calib_cnt;
  logic          r_calib_done;

  // Count edges since reset release, then hold calib_done high
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_calib_cnt  <= '0;
      r_calib_done <= 1'b0;
    end else if (!r_calib_done) begin
      r_calib_cnt <= r_calib_cnt + CW'(1);
      if (r_calib_cnt == CW'(CALIB_CYC - 1)) r_calib_done <= 1'b1;
    end
  end

  assign calib_done = r_calib_done;

  // ---------------------------------------------------------------------------
  // Command FIFO, depth 4. Only the AW word-address bits are kept.
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0] r_cmd_mem [0:3];
  logic [1:0]       r_cmd_wptr, r_cmd_rptr;
  logic [2:0]       r_cmd_cnt;
  logic             w_cmd_push, w_cmd_pop;
  logic [CMD_W-1:0] w_cmd_head;
  logic [2:0]       w_head_instr;
  logic [5:0]       w_head_bl;
  logic [AW-1:0]    w_head_addr;
  logic             w_head_wr, w_head_rd;
  logic             w_unused_addr;

  assign cmd_full   = (r_cmd_cnt == 3'd4);
  assign cmd_empty  = (r_cmd_cnt == 3'd0);
  assign w_cmd_push = cmd_en && !cmd_full;

  // Byte-lane and out-of-range address bits carry no meaning for this array
  assign w_unused_addr = ^{cmd_byte_addr[29:AW+2], cmd_byte_addr[1:0]};

  // Command storage (contents need no reset)
  always_ff @(posedge wb_clk_i) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wptr] <= {cmd_instr, cmd_bl, cmd_byte_addr[AW+1:2]};
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cmd_wptr <= '0;
      r_cmd_rptr <= '0;
      r_cmd_cnt  <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + 2'd1;
      if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + 2'd1;
      r_cmd_cnt <= r_cmd_cnt + 3'(w_cmd_push) - 3'(w_cmd_pop);
    end
  end

  assign w_cmd_head   = r_cmd_mem[r_cmd_rptr];
  assign w_head_instr = w_cmd_head[CMD_W-1 -: 3];
  assign w_head_bl    = w_cmd_head[AW +: 6];
  assign w_head_addr  = w_cmd_head[AW-1:0];
  assign w_head_wr    = !w_head_instr[2] && !w_head_instr[0];
  assign w_head_rd    = !w_head_instr[2] &&  w_head_instr[0];

  // ---------------------------------------------------------------------------
  // Write FIFO, depth 64 of {mask, data}
  // ---------------------------------------------------------------------------
  logic [35:0] r_wr_mem [0:63];
  logic [5:0]  r_wr_wptr, r_wr_rptr;
  logic [6:0]  r_wr_cnt;
  logic        w_wr_push, w_wr_pop;
  logic [35:0] w_wr_head;
  logic        r_wr_underrun, r_wr_error;

  assign wr_full   = (r_wr_cnt == 7'd64);
  assign wr_empty  = (r_wr_cnt == 7'd0);
  assign wr_count  = r_wr_cnt;
  assign w_wr_push = wr_en && !wr_full;
  assign w_wr_head = r_wr_mem[r_wr_rptr];

  // Write-beat storage
  always_ff @(posedge wb_clk_i) begin
    if (w_wr_push) r_wr_mem[r_wr_wptr] <= {wr_mask, wr_data};
  end

  // Write FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wr_wptr <= '0;
      r_wr_rptr <= '0;
      r_wr_cnt  <= '0;
    end else begin
      if (w_wr_push) r_wr_wptr <= r_wr_wptr + 6'd1;
      if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + 6'd1;
      r_wr_cnt <= r_wr_cnt + 7'(w_wr_push) - 7'(w_wr_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Read FIFO, depth 64, first-word-fall-through
  // ---------------------------------------------------------------------------
  logic [31:0] r_rd_mem [0:63];
  logic [5:0]  r_rd_wptr, r_rd_rptr;
  logic [6:0]  r_rd_cnt;
  logic        w_rd_push, w_rd_pop;
  logic        r_rd_vld;
  logic [31:0] r_rd_q;
  logic        r_rd_overflow, r_rd_error;

  assign rd_full   = (r_rd_cnt == 7'd64);
  assign rd_empty  = (r_rd_cnt == 7'd0);
  assign rd_count  = r_rd_cnt;
  assign rd_data   = r_rd_mem[r_rd_rptr];
  assign w_rd_push = r_rd_vld && !rd_full;
  assign w_rd_pop  = rd_en && !rd_empty;

  // Read-beat storage
  always_ff @(posedge wb_clk_i) begin
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= r_rd_q;
  end

  // Read FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rd_wptr <= '0;
      r_rd_rptr <= '0;
      r_rd_cnt  <= '0;
    end else begin
      if (w_rd_push) r_rd_wptr <= r_rd_wptr + 6'd1;
      if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + 6'd1;
      r_rd_cnt <= r_rd_cnt + 7'(w_rd_push) - 7'(w_rd_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Executor FSM
  // ---------------------------------------------------------------------------
  state_t        r_state, w_next;
  logic [5:0]    r_beat_cnt;
  logic [AW-1:0] r_addr;
  logic          w_underrun, w_rd_issue;

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next state: commands start only once calibrated; last beat returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_calib_done && !cmd_empty) begin
          if (w_head_wr)      w_next = S_WRITE;
          else if (w_head_rd) w_next = S_READ;
          else                w_next = S_IDLE;
        end
      end
      S_WRITE, S_READ: begin
        if (r_beat_cnt == 6'd0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: a write beat consumes the FIFO head or underruns; reads never stall
  always_comb begin
    w_cmd_pop  = 1'b0;
    w_wr_pop   = 1'b0;
    w_underrun = 1'b0;
    w_rd_issue = 1'b0;
    case (r_state)
      S_IDLE:  w_cmd_pop  = r_calib_done && !cmd_empty;
      S_WRITE: begin
        w_wr_pop   = !wr_empty;
        w_underrun = wr_empty;
      end
      S_READ:  w_rd_issue = 1'b1;
      default: ;
    endcase
  end

  // Beat counter and word address; address wraps naturally at 2^AW
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_beat_cnt <= '0;
      r_addr     <= '0;
    end else if (w_cmd_pop) begin
      r_beat_cnt <= w_head_bl;
      r_addr     <= w_head_addr;
    end else if (r_state != S_IDLE) begin
      r_beat_cnt <= r_beat_cnt - 6'd1;
      r_addr     <= r_addr + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Backing array: byte-masked writes, synchronous read (not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] r_mem [0:(2**AW)-1];

  // Array write and registered read port
  always_ff @(posedge wb_clk_i) begin
    if (w_wr_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (!w_wr_head[32+b]) r_mem[r_addr][8*b +: 8] <= w_wr_head[8*b +: 8];
      end
    end
    r_rd_q <= r_mem[r_addr];
  end

  // Read-data valid stage, pulses and sticky error flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rd_vld      <= 1'b0;
      r_wr_underrun <= 1'b0;
      r_rd_overflow <= 1'b0;
      r_wr_error    <= 1'b0;
      r_rd_error    <= 1'b0;
    end else begin
      r_rd_vld      <= w_rd_issue;
      r_wr_underrun <= w_underrun;
      r_rd_overflow <= r_rd_vld && rd_full;
      if (w_underrun || (wr_en && wr_full))                  r_wr_error <= 1'b1;
      if ((r_rd_vld && rd_full) || (rd_en && rd_empty))      r_rd_error <= 1'b1;
    end
  end

  assign wr_underrun = r_wr_underrun;
  assign wr_error    = r_wr_error;
  assign rd_overflow = r_rd_overflow;
  assign rd_error    = r_rd_error;

endmodule
